rf_bank: RTL and testbench
==========================

Name: rf_bank

Overview:
Parametrised general-purpose register file for the pipelined CPU. It provides N combinational read ports, one synchronous write port with optional write-through bypass, and a hardwired zero register. It also contains an integrated busy scoreboard, so the ID stage can detect RAW hazards against producers that have issued but not yet written back. It sits between ID (reads, busy_set) and WB (write, busy_clr); a debug read port feeds the board display.

Parameters:
XLEN, 32, data width in bits
ADDR_W, 5, register address width; depth NREG = 2**ADDR_W
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes; 0 = register 0 is an ordinary register
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value only

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
we  in  1  write enable (WB stage)
waddr  in  ADDR_W  write address
wdata  in  XLEN  write data
raddr  in  NRD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
rdata  out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
rbusy  out  NRD  port i's register has a pending producer
busy_set  in  1  mark busy_addr busy (instruction issued with a destination)
busy_addr  in  ADDR_W  destination to mark busy
busy_clr  in  1  clear busy bit of waddr (normally tied to we)
dbg_addr  in  ADDR_W  debug read address
dbg_data  out  XLEN  debug read data (stored value, no bypass)
busy_cnt  out  ADDR_W+1  number of registers currently busy

Behaviour:
- Reset (async, rst=1): every register is 0, every busy bit is 0, busy_cnt=0. Consequently all rdata=0, rbusy=0, dbg_data=0 while rst is held. An asserted rst aborts any same-edge write or set.
- Write: on posedge clk, if we and not rst, then reg[waddr] <= wdata. With ZERO_REG=1 and waddr=0 the write is discarded.
- Read, combinational, zero latency, for each port i:
  - If ZERO_REG=1 and raddr_i=0, rdata_i=0.
  - Else if BYPASS=1 and we and waddr==raddr_i, rdata_i=wdata (write-first).
  - Else rdata_i=reg[raddr_i].
  - With BYPASS=0, the new value is visible the cycle after the write edge.
- Scoreboard, per-register busy bit b[r], updated on posedge:
  - busy_set sets b[busy_addr].
  - busy_clr clears b[waddr].
  - Same register set and cleared on one edge: set wins (a new producer has issued), and b stays 1.
  - Different registers: both actions apply.
  - Set of an already-busy register: stays 1. Clear of an idle register: no effect.
  - ZERO_REG=1: b[0] is never set.
- rbusy_i = b[raddr_i], except:
  - forced 0 when BYPASS=1 and busy_clr and waddr==raddr_i and we (value is forwarded this cycle);
  - forced 0 when ZERO_REG=1 and raddr_i=0.
- busy_cnt: registered population count of b, updated on the same edge as b; range 0..NREG.
- All NRD ports may address the same register simultaneously; there are no port conflicts.
- Parameter legality:
  - NRD outside 1..4 → elaboration error via generate-time check.
  - XLEN < 1 or ADDR_W < 1 → elaboration error.

Test Plan:
- Reset then read all 32 regs on both ports → rdata=0, rbusy=0, busy_cnt=0. Assert rst mid-write (we=1, waddr=3, wdata=0xDEADBEEF) → reg3 stays 0.
- Write reg5=0x12345678 while port0 reads 5: with BYPASS=1, rdata0=0x12345678 in the same cycle. With BYPASS=0, rdata0=0 that cycle and 0x12345678 the next cycle.
- Write reg0=0xFFFFFFFF with ZERO_REG=1 → rdata and dbg_data for addr 0 read 0. Same write with ZERO_REG=0 → 0xFFFFFFFF the next cycle.
- busy_set reg7, then port1 reads 7 → rbusy1=1, busy_cnt=1. Then we=busy_clr=1, waddr=7, wdata=0xA5 → rbusy1=0 that cycle with rdata1=0xA5; busy_cnt=0 after the edge.
- Same edge: busy_set reg9 and busy_clr with waddr=9 → b[9]=1 after the edge, busy_cnt unchanged at +1. Set reg3 and clear reg4 (reg4 previously busy) → b[3]=1, b[4]=0.
- NRD=4: all four ports read reg12=0x0BADF00D while port3 reads 0 → ports 0-2 return 0x0BADF00D, port3 returns 0. Busy-set all 31 nonzero regs → busy_cnt=31.

Source files
------------

// File: rtl/rf_bank.sv
// General-purpose register file with combinational read ports, one write port,
// optional write-through bypass, hardwired zero register and a busy scoreboard.
module rf_bank #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  busy_set,
    input  logic [ADDR_W-1:0]     busy_addr,
    input  logic                  busy_clr,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [XLEN-1:0]       dbg_data,
    output logic [ADDR_W:0]       busy_cnt
);

    localparam int unsigned NREG = 2 ** ADDR_W;

    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("rf_bank: NRD must be in 1..4");
    end
    if (XLEN < 1 || ADDR_W < 1) begin : g_bad_width
        $error("rf_bank: XLEN and ADDR_W must be at least 1");
    end
    if ((ZERO_REG != 0 && ZERO_REG != 1) || (BYPASS != 0 && BYPASS != 1)) begin : g_bad_flag
        $error("rf_bank: ZERO_REG and BYPASS must be 0 or 1");
    end

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [ADDR_W:0] busy_cnt_q, busy_cnt_d;
    logic            wr_zero;
    logic            set_zero;
    logic            we_live;

    assign wr_zero  = (ZERO_REG != 0) && (waddr == '0);
    assign set_zero = (ZERO_REG != 0) && (busy_addr == '0);
    // Forwarding must not leak wdata onto the read ports while reset is held.
    assign we_live  = we && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else if (we && !wr_zero) begin
            regs_q[waddr] <= wdata;
        end
    end

    // Clear is applied before set so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_d = busy_q;
        if (busy_clr) begin
            busy_d[waddr] = 1'b0;
        end
        if (busy_set && !set_zero) begin
            busy_d[busy_addr] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt_d = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic              hit;
        rdata = '0;
        rbusy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            ra  = raddr[i*ADDR_W +: ADDR_W];
            hit = (BYPASS != 0) && we_live && (waddr == ra);
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rdata[i*XLEN +: XLEN] = '0;
                rbusy[i]              = 1'b0;
            end else begin
                rdata[i*XLEN +: XLEN] = hit ? wdata : regs_q[ra];
                rbusy[i]              = busy_q[ra] && !(hit && busy_clr);
            end
        end
    end

    always_comb begin
        dbg_data = regs_q[dbg_addr];
        if ((ZERO_REG != 0) && (dbg_addr == '0)) begin
            dbg_data = '0;
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_rf_bank.sv
// Bench for rf_bank: three configurations driven in lockstep, checked against
// hand-derived vectors and an array-based reference model of the register file.
module tb_rf_bank;

    logic        clk = 1'b0;
    logic        rst, we, busy_set, busy_clr;
    logic [4:0]  waddr, busy_addr, dbg_addr;
    logic [31:0] wdata;
    logic [4:0]  ra [4];
    logic [9:0]  raddr2;
    logic [19:0] raddr4;

    logic [63:0]  rdata_m;  logic [1:0] rbusy_m; logic [31:0] dbg_m; logic [5:0] cnt_m;
    logic [127:0] rdata_a;  logic [3:0] rbusy_a; logic [31:0] dbg_a; logic [5:0] cnt_a;
    logic [127:0] rdata_q;  logic [3:0] rbusy_q; logic [31:0] dbg_q; logic [5:0] cnt_q;

    assign raddr2 = {ra[1], ra[0]};
    assign raddr4 = {ra[3], ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    rf_bank u_main (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr2), .rdata(rdata_m), .rbusy(rbusy_m),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_clr(busy_clr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_m), .busy_cnt(cnt_m)
    );

    rf_bank #(.XLEN(32), .ADDR_W(5), .NRD(4), .ZERO_REG(0), .BYPASS(0)) u_alt (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr4), .rdata(rdata_a), .rbusy(rbusy_a),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_clr(busy_clr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_a), .busy_cnt(cnt_a)
    );

    rf_bank #(.XLEN(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1), .BYPASS(1)) u_quad (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr4), .rdata(rdata_q), .rbusy(rbusy_q),
        .busy_set(busy_set), .busy_addr(busy_addr), .busy_clr(busy_clr),
        .dbg_addr(dbg_addr), .dbg_data(dbg_q), .busy_cnt(cnt_q)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference state per configuration: 0 = main, 1 = alt, 2 = quad.
    int          zr_c  [3] = '{1, 0, 1};
    int          bp_c  [3] = '{1, 0, 1};
    int          nrd_c [3] = '{2, 4, 4};
    logic [31:0] m_reg  [3][32];
    bit          m_busy [3][32];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] act_rd(int c, int p);
        case (c)
            0:       return rdata_m[p*32 +: 32];
            1:       return rdata_a[p*32 +: 32];
            default: return rdata_q[p*32 +: 32];
        endcase
    endfunction

    function automatic logic act_rb(int c, int p);
        case (c)
            0:       return rbusy_m[p];
            1:       return rbusy_a[p];
            default: return rbusy_q[p];
        endcase
    endfunction

    function automatic logic [31:0] act_dbg(int c);
        case (c)
            0:       return dbg_m;
            1:       return dbg_a;
            default: return dbg_q;
        endcase
    endfunction

    function automatic logic [5:0] act_cnt(int c);
        case (c)
            0:       return cnt_m;
            1:       return cnt_a;
            default: return cnt_q;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(int c, int p);
        logic [4:0] a;
        a = ra[p];
        if (zr_c[c] != 0 && a == 0) return 32'h0;
        if (bp_c[c] != 0 && we && !rst && waddr == a) return wdata;
        return m_reg[c][a];
    endfunction

    function automatic logic exp_rb(int c, int p);
        logic [4:0] a;
        a = ra[p];
        if (zr_c[c] != 0 && a == 0) return 1'b0;
        if (bp_c[c] != 0 && busy_clr && we && !rst && waddr == a) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic int exp_cnt(int c);
        int n = 0;
        for (int r = 0; r < 32; r++) n += int'(m_busy[c][r]);
        return n;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) begin
                m_reg[c][r]  = 32'h0;
                m_busy[c][r] = 1'b0;
            end
    endtask

    task automatic model_edge();
        if (rst) return;
        for (int c = 0; c < 3; c++) begin
            if (busy_clr) m_busy[c][waddr] = 1'b0;
            if (busy_set && !(zr_c[c] != 0 && busy_addr == 0)) m_busy[c][busy_addr] = 1'b1;
            if (we && !(zr_c[c] != 0 && waddr == 0)) m_reg[c][waddr] = wdata;
        end
    endtask

    task automatic model_check();
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < nrd_c[c]; p++) begin
                chk($sformatf("rdata c%0d p%0d a%0d", c, p, ra[p]), 64'(act_rd(c, p)), 64'(exp_rd(c, p)));
                chk($sformatf("rbusy c%0d p%0d a%0d", c, p, ra[p]), 64'(act_rb(c, p)), 64'(exp_rb(c, p)));
            end
            chk($sformatf("dbg c%0d a%0d", c, dbg_addr), 64'(act_dbg(c)),
                64'((zr_c[c] != 0 && dbg_addr == 0) ? 32'h0 : m_reg[c][dbg_addr]));
            chk($sformatf("busy_cnt c%0d", c), 64'(act_cnt(c)), 64'(exp_cnt(c)));
        end
    endtask

    task automatic idle();
        we = 0; waddr = 0; wdata = 0; busy_set = 0; busy_addr = 0; busy_clr = 0; dbg_addr = 0;
        for (int p = 0; p < 4; p++) ra[p] = 0;
    endtask

    task automatic pre();
        #2;
        model_check();
    endtask

    task automatic post();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        model_clear();
        pre();
        post();
        rst = 0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0, ra1;
        logic        bset;
        logic [4:0]  baddr;
        logic        bclr;
        logic [31:0] e_rd0;
        logic        e_rb1;
        logic [5:0]  e_cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        tbl[0]  = '{1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 32'h12345678, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h12345678, 1'b0, 6'd0};
        tbl[2]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 6'd0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 32'h0,        1'b0, 6'd1};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0,        1'b1, 6'd1};
        tbl[5]  = '{1'b1, 5'd7, 32'h000000A5, 5'd7, 5'd7, 1'b0, 5'd0, 1'b1, 32'h000000A5, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 32'h000000A5, 1'b0, 6'd1};
        tbl[7]  = '{1'b0, 5'd9, 32'h0,        5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 32'h0,        1'b1, 6'd1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        5'd9, 5'd9, 1'b1, 5'd4, 1'b0, 32'h0,        1'b1, 6'd2};
        tbl[9]  = '{1'b0, 5'd4, 32'h0,        5'd4, 5'd4, 1'b1, 5'd3, 1'b1, 32'h0,        1'b1, 6'd2};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 6'd2};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 6'd2};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd3, 1'b0, 5'd0, 1'b0, 32'h12345678, 1'b1, 6'd2};
        tbl[13] = '{1'b1, 5'd3, 32'h00000077, 5'd3, 5'd3, 1'b0, 5'd0, 1'b1, 32'h00000077, 1'b0, 6'd1};

        rst = 1;
        do_reset();

        // Reset state across every address on both main ports.
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) ra[p] = 5'(a);
            dbg_addr = 5'(a);
            #1;
            chk($sformatf("reset rdata0 a%0d", a), 64'(rdata_m[31:0]), 64'h0);
            chk($sformatf("reset rdata1 a%0d", a), 64'(rdata_m[63:32]), 64'h0);
            chk($sformatf("reset rbusy a%0d", a), 64'(rbusy_m), 64'h0);
        end
        chk("reset busy_cnt", 64'(cnt_m), 64'h0);

        // Reset asserted during a write: nothing lands, nothing forwards.
        idle();
        we = 1; waddr = 3; wdata = 32'hDEADBEEF; ra[0] = 3; ra[1] = 3; dbg_addr = 3;
        rst = 1;
        model_clear();
        #2;
        chk("rst bypass main", 64'(rdata_m[31:0]), 64'h0);
        chk("rst bypass quad", 64'(rdata_q[31:0]), 64'h0);
        post();
        rst = 0;
        we = 0;
        pre();
        chk("rst write reg3", 64'(rdata_m[31:0]), 64'h0);
        chk("rst write dbg3", 64'(dbg_m), 64'h0);
        post();

        // Hand-derived vectors on the default configuration.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            idle();
            we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1; ra[2] = tbl[i].ra0; ra[3] = tbl[i].ra1;
            busy_set = tbl[i].bset; busy_addr = tbl[i].baddr; busy_clr = tbl[i].bclr;
            pre();
            chk($sformatf("vec%0d rdata0", i), 64'(rdata_m[31:0]), 64'(tbl[i].e_rd0));
            chk($sformatf("vec%0d rbusy1", i), 64'(rbusy_m[1]), 64'(tbl[i].e_rb1));
            post();
            chk($sformatf("vec%0d busy_cnt", i), 64'(cnt_m), 64'(tbl[i].e_cnt));
        end

        // No-bypass: new value appears only after the write edge.
        do_reset();
        we = 1; waddr = 5; wdata = 32'h12345678; ra[0] = 5;
        pre();
        chk("nobyp same cycle", 64'(rdata_a[31:0]), 64'h0);
        chk("byp same cycle", 64'(rdata_m[31:0]), 64'h12345678);
        post();
        idle(); ra[0] = 5;
        pre();
        chk("nobyp next cycle", 64'(rdata_a[31:0]), 64'h12345678);
        post();

        // Zero register: hardwired in main, ordinary in alt.
        we = 1; waddr = 0; wdata = 32'hFFFFFFFF; ra[0] = 0; dbg_addr = 0;
        pre();
        chk("zero bypass main", 64'(rdata_m[31:0]), 64'h0);
        post();
        idle();
        pre();
        chk("zero rd main", 64'(rdata_m[31:0]), 64'h0);
        chk("zero dbg main", 64'(dbg_m), 64'h0);
        chk("zero rd alt", 64'(rdata_a[31:0]), 64'hFFFFFFFF);
        chk("zero dbg alt", 64'(dbg_a), 64'hFFFFFFFF);
        post();

        // Four ports on one register, one port on the zero register.
        we = 1; waddr = 12; wdata = 32'h0BADF00D; ra[0] = 12; ra[1] = 12; ra[2] = 12; ra[3] = 0;
        pre();
        for (int p = 0; p < 3; p++) chk($sformatf("quad p%0d bypass", p), 64'(rdata_q[p*32 +: 32]), 64'h0BADF00D);
        chk("quad p3 zero", 64'(rdata_q[127:96]), 64'h0);
        post();
        we = 0;
        pre();
        for (int p = 0; p < 3; p++) chk($sformatf("quad p%0d stored", p), 64'(rdata_q[p*32 +: 32]), 64'h0BADF00D);
        chk("alt p3 reg0", 64'(rdata_a[127:96]), 64'hFFFFFFFF);
        post();

        // Scoreboard fill up to its limits.
        do_reset();
        for (int a = 1; a < 32; a++) begin
            idle();
            busy_set = 1; busy_addr = 5'(a);
            pre();
            post();
        end
        chk("fill quad cnt", 64'(cnt_q), 64'd31);
        idle();
        busy_set = 1; busy_addr = 0;
        pre();
        post();
        chk("fill quad cnt zero set", 64'(cnt_q), 64'd31);
        chk("fill alt cnt full", 64'(cnt_a), 64'd32);

        // Randomised traffic with occasional asynchronous reset.
        do_reset();
        for (int n = 0; n < 800; n++) begin
            logic [4:0] wa;
            idle();
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            we        = 1'($urandom);
            waddr     = wa;
            wdata     = $urandom;
            busy_clr  = ($urandom_range(0, 3) == 0) ? 1'($urandom) : we;
            busy_set  = 1'($urandom);
            busy_addr = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            dbg_addr  = 5'($urandom_range(0, 7));
            for (int p = 0; p < 4; p++)
                ra[p] = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) begin
                rst = 1;
                model_clear();
            end
            pre();
            post();
            rst = 0;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
